mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch path (PC → instruction memory) and the load/store path (ALU result → data memory).
- Sits between the program counter / datapath and a single-ported memory.
- Arbitrates requests, issues one transaction at a time over a req/gnt + rvalid handshake, and returns read data with a one-cycle ack.
- Data requests have priority. A starvation counter guarantees fetch progress.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory port
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- STARVE_MAX, 4, consecutive data grants allowed while fetch is pending before fetch is forced

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_WIDTH  fetch address; stable while i_req
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_WIDTH  fetched instruction
- d_req  in  1  load/store request; held until d_ack
- d_we  in  1  1 = store
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  byte enables
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables; all ones for fetch
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response valid; returned for both reads and writes
- mem_rdata  in  DATA_WIDTH  read data
- busy  out  1  a transaction is in flight (state != IDLE)

Behaviour:
- Clock: one clock, clk. Reset: rst, asynchronous, active-high.
- All outputs are registered. Reset values:
  - state = IDLE
  - all outputs 0, including i_rdata and d_rdata
  - starve_cnt = 0, owner = DATA
- States and transitions:
  - IDLE: choose the winner from i_req/d_req, latch the winner's address, data, be and we into the mem_* registers, set owner, go to ISSUE.
  - IDLE with no request: stay.
  - ISSUE: mem_req = 1. On mem_gnt: drop mem_req next cycle, go to WAIT. Otherwise hold all mem_* stable.
  - WAIT: on mem_rvalid, capture mem_rdata into the owner's rdata register and go to RESP.
  - RESP: owner's ack = 1 for exactly this cycle; go to IDLE.
    - i_req/d_req are ignored in RESP, because the completed requester is still asserting.
    - The requester may drop or re-present req from the cycle after ack.
- Arbitration in IDLE:
  - Only d_req set: data wins.
  - Only i_req set: fetch wins.
  - Both set: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - +1 on each data grant made while i_req = 1 (saturating at STARVE_MAX).
  - Cleared on any fetch grant.
  - Unchanged on a data grant with i_req = 0.
- Latency: with gnt and rvalid each arriving at the earliest cycle, ack is asserted 3 cycles after req is first sampled in IDLE (IDLE → ISSUE → WAIT → RESP). Back-to-back service period is 4 cycles.
- Ignored inputs:
  - mem_rvalid outside WAIT is ignored, including stale responses after reset.
  - mem_gnt outside ISSUE is ignored.
- Store: d_rdata is updated with mem_rdata (don't-care content); d_ack still pulses.
- The non-owner's rdata register holds its previous value.
- Reset mid-transaction: return to IDLE immediately; mem_req drops; no ack is issued. Requesters must re-request.
- One outstanding transaction only. No pipelining.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_INSTR, OWN_DATA}
  - localparam for BE width
- No sub-module. Arbitration is a few lines of combinational logic inside the block.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0x0000_0010; memory gives gnt in ISSUE and rvalid = 1 with rdata = 0x00A0_0513 one cycle later → mem_addr = 0x10, mem_be = 0xF, mem_we = 0; i_ack pulses 3 cycles after the request with i_rdata = 0x00A0_0513; d_ack stays 0.
- Store: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, d_be = 0x3 → mem_we = 1, mem_wdata = 0xDEADBEEF, mem_be = 0x3; single d_ack pulse.
- Simultaneous i_req and d_req with starve_cnt = 0 → data is served first, then fetch; exactly one ack each; starve_cnt = 1, then cleared to 0.
- Starvation: d_req held continuously (re-requested after every ack) with i_req = 1, STARVE_MAX = 4 → 4 data grants, then the 5th grant goes to fetch.
- Memory stall: mem_gnt held low for 5 cycles, then rvalid arrives 3 cycles after gnt → mem_req and mem_addr stable throughout; ack arrives 1 cycle after rvalid; spurious rvalid in IDLE causes no ack.
- Reset in WAIT: assert rst mid-transaction, then deliver rvalid after release → busy = 0, mem_req = 0, no ack; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, transaction
// owner and default bus widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BE_WIDTH_DEF   = DATA_WIDTH_DEF / 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-ported memory bus: req/gnt request phase plus rvalid response phase.
// The arbiter drives the master side, the memory drives the slave side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port, one
// transaction at a time; data has priority, bounded by a starvation counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ack,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  mem_arbiter_if.master           bus,
  output logic                    busy
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  state_t        state;
  owner_t        owner;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          fetch_wins;

  always_comb begin
    starved    = (starve_cnt == CW'(STARVE_MAX));
    fetch_wins = i_req && (!d_req || starved);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_DATA;
      starve_cnt    <= '0;
      busy          <= 1'b0;
      i_ack         <= 1'b0;
      d_ack         <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            bus.mem_req <= 1'b1;
            if (fetch_wins) begin
              owner         <= OWN_INSTR;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= i_addr;
              bus.mem_wdata <= '0;
              bus.mem_be    <= '1;
              starve_cnt    <= '0;
            end else begin
              owner         <= OWN_DATA;
              bus.mem_we    <= d_we;
              bus.mem_addr  <= d_addr;
              bus.mem_wdata <= d_wdata;
              bus.mem_be    <= d_be;
              // Only count grants that actually made a pending fetch wait.
              if (i_req && !starved)
                starve_cnt <= starve_cnt + CW'(1);
            end
          end
        end
        ISSUE: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state <= RESP;
            if (owner == OWN_INSTR) begin
              i_rdata <= bus.mem_rdata;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= bus.mem_rdata;
              d_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          // Requests are not sampled here: the finished requester still holds req.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
